// File: rtl/bf_pkg.sv
// bf_pkg: bus opcodes, pin-bus phases and opcode classification shared by the BF I/O path.
package bf_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        BusNone    = 3'd0,
        BusRead    = 3'd1,
        BusWrite   = 3'd2,
        BusFetch   = 3'd3,
        BusIoRead  = 3'd4,
        BusIoWrite = 3'd5
    } BusOp;

    typedef enum logic [1:0] {
        PhIdle   = 2'd0,
        PhOpcode = 2'd1,
        PhAddr   = 2'd2,
        PhData   = 2'd3
    } IoPhase;

    function automatic logic op_is_read(BusOp op);
        return op inside {BusRead, BusFetch, BusIoRead};
    endfunction

endpackage

// File: rtl/io_watchdog.sv
// io_watchdog: counts stalled data-beat cycles and flags expiry on the TIMEOUT-th one.
module io_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clock,
    input  logic reset_n,
    input  logic enable,
    input  logic count_en,
    input  logic clear,
    output logic expired
);

    localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;

    logic [TW-1:0] cnt_q, cnt_d;

    always_comb begin
        expired = (TIMEOUT != 0) && count_en && !clear && (cnt_q == TW'(TIMEOUT - 1));
        cnt_d   = (clear || expired) ? '0 : count_en ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n)
            cnt_q <= '0;
        else if (enable)
            cnt_q <= cnt_d;

endmodule

// File: rtl/io_bridge.sv
// io_bridge: serialises BF core bus operations into opcode/address/data beats on a narrow pin bus.
// Upper address beats are elided when they match the previously sent upper address.
module io_bridge
    import bf_pkg::*;
#(
    parameter int ADDR_W  = 15,
    parameter int DATA_W  = 8,
    parameter int PIN_W   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              enable,
    input  BusOp              bus_op,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] val_out,
    output logic [DATA_W-1:0] val_in,
    output logic              core_en,
    output logic [PIN_W-1:0]  pin_out,
    input  logic [PIN_W-1:0]  pin_in,
    input  logic              op_done,
    output IoPhase            phase,
    output logic              err
);

    localparam int AB = (ADDR_W + PIN_W - 1) / PIN_W;
    localparam int DB = DATA_W / PIN_W;
    localparam int AP = AB * PIN_W;
    localparam int NB = AB > DB ? AB : DB;
    localparam int CW = NB > 1 ? $clog2(NB) : 1;

    IoPhase            phase_q, phase_d;
    BusOp              op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d, upper_q, upper_d;
    logic [DATA_W-1:0] wdat_q, wdat_d, rd_q, rd_d, val_q, val_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              last_q, last_d, err_q, err_d;

    logic              elide, is_rd, expired;
    logic [AP-1:0]     addr_pad;
    logic [CW-1:0]     asel;
    logic [PIN_W-1:0]  a_beat, d_beat;
    logic [DATA_W-1:0] rd_next;

    io_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clock   (clock),
        .reset_n (reset_n),
        .enable  (enable),
        .count_en(enable && phase_q == PhData && !op_done),
        .clear   (phase_q != PhData || op_done),
        .expired (expired)
    );

    always_comb begin
        elide    = (AB > 1) && last_q && ((addr_q >> PIN_W) == upper_q);
        is_rd    = op_is_read(op_q);
        addr_pad = AP'(addr_q);
        asel     = elide ? CW'(AB - 1) : cnt_q;
        a_beat   = PIN_W'(addr_pad >> ((AB - 1 - asel) * PIN_W));
        d_beat   = PIN_W'(wdat_q >> ((DB - 1 - cnt_q) * PIN_W));
        rd_next  = (rd_q << PIN_W) | DATA_W'(pin_in);
    end

    always_comb begin
        phase_d = phase_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdat_d  = wdat_q;
        rd_d    = rd_q;
        val_d   = val_q;
        upper_d = upper_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        err_d   = err_q;
        pin_out = '0;
        core_en = 1'b0;
        case (phase_q)
            PhIdle: begin
                core_en = enable;
                if (bus_op != BusNone) begin
                    op_d    = bus_op;
                    addr_d  = addr;
                    wdat_d  = val_out;
                    rd_d    = '0;
                    cnt_d   = '0;
                    phase_d = PhOpcode;
                end
            end
            PhOpcode: begin
                pin_out            = PIN_W'(op_q);
                pin_out[PIN_W-1]   = elide;
                cnt_d              = '0;
                phase_d            = PhAddr;
            end
            PhAddr: begin
                pin_out = a_beat;
                if (elide || cnt_q == CW'(AB - 1)) begin
                    upper_d = addr_q >> PIN_W;
                    last_d  = 1'b1;
                    cnt_d   = '0;
                    phase_d = PhData;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PhData: begin
                pin_out = d_beat;
                if (op_done) begin
                    rd_d = is_rd ? rd_next : rd_q;
                    if (cnt_q == CW'(DB - 1)) begin
                        val_d   = is_rd ? rd_next : val_q;
                        cnt_d   = '0;
                        phase_d = PhIdle;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (expired) begin
                    // abandoned handshake: poison read data and force a full address next time
                    val_d   = is_rd ? '1 : val_q;
                    err_d   = 1'b1;
                    last_d  = 1'b0;
                    cnt_d   = '0;
                    phase_d = PhIdle;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            phase_q <= PhIdle;
            op_q    <= BusNone;
            addr_q  <= '0;
            wdat_q  <= '0;
            rd_q    <= '0;
            val_q   <= '0;
            upper_q <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else if (enable) begin
            phase_q <= phase_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdat_q  <= wdat_d;
            rd_q    <= rd_d;
            val_q   <= val_d;
            upper_q <= upper_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end

    assign val_in = val_q;
    assign phase  = phase_q;
    assign err    = err_q;

endmodule

// File: tb/tb_io_bridge.sv
// tb_io_bridge: randomized transactions checked beat-by-beat against a transaction-level model.
module tb_io_bridge;
    import bf_pkg::*;

    localparam int AW = 15;
    localparam int DW = 16;
    localparam int PW = 8;
    localparam int TO = 4;
    localparam int DB = DW / PW;

    logic          clock   = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable  = 1'b1;
    logic          op_done = 1'b0;
    BusOp          bus_op  = BusNone;
    logic [AW-1:0] addr    = '0;
    logic [DW-1:0] val_out = '0;
    logic [PW-1:0] pin_in  = '0;
    logic [DW-1:0] val_in;
    logic          core_en;
    logic [PW-1:0] pin_out;
    IoPhase        phase;
    logic          err;

    int n_err = 0;
    int n_chk = 0;

    logic          m_lv  = 1'b0;
    logic [AW-1:0] m_up  = '0;
    logic          m_err = 1'b0;
    logic [DW-1:0] m_val = '0;

    always #5 clock = ~clock;

    io_bridge #(.ADDR_W(AW), .DATA_W(DW), .PIN_W(PW), .TIMEOUT(TO)) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .enable (enable),
        .bus_op (bus_op),
        .addr   (addr),
        .val_out(val_out),
        .val_in (val_in),
        .core_en(core_en),
        .pin_out(pin_out),
        .pin_in (pin_in),
        .op_done(op_done),
        .phase  (phase),
        .err    (err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_phase"}, 32'(phase), 32'(0));
        check({tag, "_pin"}, 32'(pin_out), 32'(0));
        check({tag, "_core_en"}, 32'(core_en), 32'(enable));
        check({tag, "_val_in"}, 32'(val_in), 32'(m_val));
        check({tag, "_err"}, 32'(err), 32'(m_err));
    endtask

    task automatic idle_cycle(input bit frozen);
        step();
        enable = !frozen;
        bus_op = frozen ? BusOp'($urandom_range(1, 5)) : BusNone;
        op_done = 1'($urandom);
        #1;
        check_idle(frozen ? "frz" : "gap");
    endtask

    task automatic do_txn(input BusOp op, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input int p_done, input bit rst_mid, input bit stall);
        bit         rd;
        bit         el;
        bit         done;
        logic [7:0] q[$];
        logic [DW-1:0] rw;
        int         k, j, wd, guard;
        rd = (op == BusRead) || (op == BusFetch) || (op == BusIoRead);
        step();
        enable  = 1'b1;
        bus_op  = op;
        addr    = a;
        val_out = d;
        op_done = 1'($urandom);
        #1;
        check_idle("cap");
        el = m_lv && ((a >> PW) == m_up);
        q.push_back({el, 4'b0000, op});
        if (!el) q.push_back(8'(a >> PW));
        q.push_back(a[7:0]);
        k = 0;
        guard = 0;
        while (k < q.size()) begin
            step();
            enable  = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            bus_op  = BusOp'($urandom_range(0, 5));
            addr    = AW'($urandom);
            val_out = DW'($urandom);
            op_done = 1'($urandom);
            #1;
            check("hdr_phase", 32'(phase), k == 0 ? 32'(1) : 32'(2));
            check("hdr_pin", 32'(pin_out), 32'(q[k]));
            check("hdr_core_en", 32'(core_en), 32'(0));
            if (enable) k++;
            if (++guard > 200) begin
                $display("FAIL hdr_guard got=%0d exp=<200", guard);
                $fatal(1);
            end
        end
        m_up = a >> PW;
        m_lv = 1'b1;
        j = 0;
        wd = 0;
        rw = '0;
        done = 1'b0;
        guard = 0;
        while (!done) begin
            step();
            enable  = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            op_done = $urandom_range(0, 99) < p_done;
            pin_in  = PW'($urandom);
            #1;
            check("dat_phase", 32'(phase), 32'(3));
            check("dat_pin", 32'(pin_out), 32'(8'(d >> (PW * (DB - 1 - j)))));
            check("dat_core_en", 32'(core_en), 32'(0));
            if (rst_mid) begin
                reset_n = 1'b0;
                m_lv = 1'b0;
                m_err = 1'b0;
                m_val = '0;
                #1;
                check_idle("rst");
                step();
                #2;
                reset_n = 1'b1;
                return;
            end
            if (enable) begin
                if (op_done) begin
                    rw = (rw << PW) | DW'(pin_in);
                    j++;
                    wd = 0;
                    if (j == DB) begin
                        done = 1'b1;
                        if (rd) m_val = rw;
                    end
                end else if (++wd == TO) begin
                    done = 1'b1;
                    m_err = 1'b1;
                    m_lv = 1'b0;
                    if (rd) m_val = '1;
                end
            end
            if (++guard > 500) begin
                $display("FAIL dat_guard got=%0d exp=<500", guard);
                $fatal(1);
            end
        end
    endtask

    initial begin
        BusOp op;
        logic [AW-1:0] a;
        int pd;
        #3;
        check_idle("reset");
        #9 reset_n = 1'b1;
        do_txn(BusWrite, 15'h1234, 16'hA55A, 100, 1'b0, 1'b0);
        do_txn(BusRead, 15'h1256, 16'h0000, 100, 1'b0, 1'b0);
        do_txn(BusRead, 15'h1278, 16'h0000, 50, 1'b0, 1'b0);
        do_txn(BusRead, 15'h1290, 16'h0000, 0, 1'b0, 1'b0);
        do_txn(BusWrite, 15'h12AB, 16'hC3C3, 100, 1'b0, 1'b1);
        do_txn(BusIoRead, 15'h7F00, 16'h0000, 0, 1'b0, 1'b1);
        for (int n = 0; n < 200; n++) begin
            op = BusOp'($urandom_range(1, 5));
            a  = $urandom_range(0, 1) ? AW'({m_up[6:0], 8'($urandom)}) : AW'($urandom);
            pd = $urandom_range(0, 2) == 0 ? 100 : $urandom_range(0, 1) ? 60 : 20;
            do_txn(op, a, DW'($urandom), pd, 1'b0, 1'b1);
            for (int g = $urandom_range(0, 2); g > 0; g--)
                idle_cycle($urandom_range(0, 1) == 1);
        end
        do_txn(BusWrite, 15'h3344, 16'h0000, 100, 1'b0, 1'b0);
        do_txn(BusRead, 15'h3355, 16'hBEEF, 0, 1'b1, 1'b0);
        do_txn(BusRead, 15'h3366, 16'h1111, 100, 1'b0, 1'b1);
        idle_cycle(1'b0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/io_bridge.md
# io_bridge

Parametrised successor to the chip-level bus multiplexer. It serialises each bus operation from the BF core (opcode, address, data) onto a narrow pin bus in beats, and returns read data. It adds configurable data, address and pin widths, multi-beat data, upper-address elision and a handshake watchdog. It sits between `BF` and the top-level pads.

## Interface
Parameters:
- `ADDR_W`, 15: core address width.
- `DATA_W`, 8: core data width; must be a multiple of `PIN_W`.
- `PIN_W`, 8: pin bus width; must be ≥ 4 (opcode bits plus elide flag).
- `TIMEOUT`, 255: maximum cycles to wait for `op_done` on one data beat; 0 disables the watchdog.

Ports:
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `enable` in 1: global advance; low freezes every register.
- `bus_op` in `BusOp`: core request; `BusNone` means idle.
- `addr` in `ADDR_W`: core address.
- `val_out` in `DATA_W`: core write data.
- `val_in` out `DATA_W`: read data returned to the core.
- `core_en` out 1: core advance enable.
- `pin_out` out `PIN_W`: beat driven to pads.
- `pin_in` in `PIN_W`: beat sampled from pads.
- `op_done` in 1: external acknowledge of the current data beat.
- `phase` out `IoPhase` (2 bits): current phase, exported to pads.
- `err` out 1: sticky watchdog error.

## Operation
- Derived constants:
  - `AB = ceil(ADDR_W/PIN_W)` address beats, most-significant beat first; the top beat is zero-padded.
  - `DB = DATA_W/PIN_W` data beats, most-significant beat first.
- Phases: `PhIdle=0`, `PhOpcode=1`, `PhAddr=2`, `PhData=3`.
- PhIdle:
  - `core_en = enable`; `pin_out = 0`.
  - If `bus_op != BusNone`, capture `bus_op`, `addr` and `val_out` into caches, then go to PhOpcode.
- PhOpcode:
  - `pin_out = {elide, zeros, op}`, where `elide` is the MSB.
  - `elide = 1` iff `last_valid` is set and `addr[ADDR_W-1:PIN_W]` equals the previously sent upper address.
  - `elide` is forced to 0 when `AB == 1`.
  - Next phase: PhAddr.
- PhAddr:
  - If `elide` is set, only the low beat is sent (1 cycle). Otherwise all `AB` beats are sent, one per enabled cycle.
  - After the final address beat: update the stored upper address, set `last_valid`, go to PhData.
- PhData:
  - `pin_out` = the current write-data beat; it is driven for reads too.
  - A beat completes on any enabled cycle with `op_done = 1`.
  - For reads (`op_is_read(op)`), `pin_in` is shifted into the read shift register on each completed beat.
  - After beat `DB-1` completes, go to PhIdle. For reads, `val_in` loads the assembled word in that same edge.
- Watchdog:
  - Counts enabled PhData cycles without `op_done`; it resets on every completed beat.
  - On reaching `TIMEOUT` with no `op_done`:
    - abort to PhIdle;
    - set `err`;
    - for reads, set `val_in` to all ones;
    - clear `last_valid`.
- `err` is cleared only by reset.
- `core_en` is 0 in every phase except PhIdle.
- Reset values: `phase = PhIdle`, `pin_out = 0`, `val_in = 0`, `err = 0`, `last_valid = 0`, all counters 0, caches 0. `core_en` follows `enable` after reset.
- Reset asserted mid-transaction aborts immediately, with no further beats.

## Timing
- Minimum transaction length:
  - full address: `1 + 1 + AB + DB` cycles, counting the PhIdle capture cycle;
  - elided address: `1 + 1 + 1 + DB` cycles.
- Elision saves `AB-1` cycles per transaction.
- `op_done` is sampled only in PhData. It is ignored in every other phase, including an `op_done` already high on PhData entry from a prior cycle; the first PhData cycle samples normally.
- `op_done` held high completes one beat per cycle.
- `val_in` becomes valid in the first PhIdle cycle, i.e. the same cycle `core_en` rises.
- With `enable = 0`: no state, counter or output register changes, and the watchdog does not count.
- Back-to-back requests: `bus_op` non-None in the first PhIdle cycle after a transaction starts the next one; there is no bubble beyond that capture cycle.

## Structure
- Shared package `bf_pkg`:
  - `BusOp` enum with `BusNone = 0`;
  - `IoPhase` enum;
  - function `op_is_read(BusOp)`.
- Widths derived from parameters (`AB`, `DB`, beat counter widths) are localparams in the module.
- One sub-module, `io_watchdog`:
  - parametrised on `TIMEOUT`;
  - inputs `count_en`, `clear`; output `expired`;
  - same clock, reset and enable as the parent.

## Test plan
- Defaults, write `addr=15'h1234`, `val_out=8'hA5`, `op_done=1` in the data beat:
  - `pin_out` sequence `op`, `8'h12`, `8'h34`, `8'hA5`;
  - phases 1, 2, 2, 3;
  - `core_en` low for 4 cycles.
- Same write, then a read at `15'h1256`:
  - opcode beat has MSB = 1;
  - a single address beat `8'h56`;
  - `pin_in=8'h3C` gives `val_in=8'h3C` on return to PhIdle.
- `DATA_W=16`, `PIN_W=8`, read:
  - `op_done` pulses two cycles apart with `pin_in` values `8'hDE`, `8'hAD`;
  - `val_in = 16'hDEAD`;
  - the phase stays PhData between the pulses.
- `TIMEOUT=4`, read, no `op_done`:
  - returns to PhIdle after 4 PhData cycles;
  - `err=1`, `val_in = 8'hFF`;
  - the next transaction does not elide.
- `enable` dropped for 3 cycles in PhAddr:
  - `pin_out` and `phase` are held;
  - the watchdog does not advance;
  - the transaction completes unchanged after resume.
- `reset_n` pulsed low in PhData:
  - all outputs are at reset values asynchronously;
  - `err=0`;
  - the first transaction after reset sends full address beats.
